// File: rtl/riscv_pkg.sv
// Shared pipeline constants: operand-forwarding mux select codes and register index width.
package riscv_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } ex_shadow_t;

  // The producer currently in EX is the youngest, so it is checked first.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic                 ex_regwrite,
    input logic [REG_IDX_W-1:0] mem_rd,
    input logic                 mem_regwrite
  );
    if (ex_regwrite && (ex_rd != '0) && (ex_rd == rs))
      return FWD_MEM;
    else if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_sat_counter.sv
// Saturating up-counter: one-cycle update, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding/hazard control for the 5-stage pipeline: registered EX operand selects (1 cycle),
// combinational load-use stall and branch flush; a flush overrides a simultaneous stall.
module hazard_fwd_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 ex_branch_taken,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  ex_shadow_t           ex_q;
  logic [REG_IDX_W-1:0] mem_rd;
  logic                 mem_regwrite;

  logic load_use;
  logic flush;
  logic stall;

  // A WB-stage shadow would have no reader: the write-through register file
  // already covers a WB producer feeding the instruction in ID.
  always_comb begin
    load_use = id_valid && ex_q.memread && (ex_q.rd != '0) &&
               ((id_use_rs1 && (ex_q.rd == id_rs1)) ||
                (id_use_rs2 && (ex_q.rd == id_rs2)));
    flush        = ex_branch_taken;
    stall        = load_use && !flush;
    if_id_flush  = flush;
    id_ex_bubble = load_use || flush;
    pc_write     = !stall;
    if_id_write  = !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      fwd_a_sel    <= FWD_RF;
      fwd_b_sel    <= FWD_RF;
    end else begin
      mem_rd       <= ex_q.rd;
      mem_regwrite <= ex_q.regwrite;

      if (id_ex_bubble || !id_valid)
        ex_q <= '0;
      else
        ex_q <= '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};

      // Selects are for the instruction entering EX; a bubble reads nothing.
      if (id_ex_bubble) begin
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else begin
        fwd_a_sel <= fwd_sel(id_rs1, ex_q.rd, ex_q.regwrite, mem_rd, mem_regwrite);
        fwd_b_sel <= fwd_sel(id_rs2, ex_q.rd, ex_q.regwrite, mem_rd, mem_regwrite);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs from an in-flight instruction model.
module tb_hazard_fwd_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic          ex_branch_taken;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [CW-1:0] stall_count, flush_count;

  hazard_fwd_ctrl #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fa, fb, pcw, ifw, ifl, bub, sc, fc;
  } exp_t;

  typedef struct {
    bit we, ld;
    int rd;
  } instr_t;

  exp_t   sb[$];
  instr_t flight[2];   // [0] = instruction now in EX, [1] = instruction now in MEM
  int     m_fa, m_fb, m_sc, m_fc;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Youngest in-flight writer of rs: EX one -> MEM result next cycle (2), MEM one -> WB (1).
  function automatic int src_of(input int rs);
    for (int i = 0; i < 2; i++)
      if (flight[i].we && flight[i].rd != 0 && flight[i].rd == rs)
        return (i == 0) ? 2 : 1;
    return 0;
  endfunction

  task automatic cyc(input bit rst, input bit v, input int rs1, input int rs2,
                     input bit u1, input bit u2, input int rd, input bit we,
                     input bit ld, input bit br);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst_n = rst; id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
    id_regwrite = we; id_memread = ld; ex_branch_taken = br;
    if (!rst) begin
      flight[0] = '{0, 0, 0}; flight[1] = '{0, 0, 0};
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    end
    lu = v && flight[0].ld && flight[0].rd != 0 &&
         ((u1 && flight[0].rd == rs1) || (u2 && flight[0].rd == rs2));
    e.fa = m_fa; e.fb = m_fb;
    e.pcw = (lu && !br) ? 0 : 1;
    e.ifw = e.pcw;
    e.ifl = br ? 1 : 0;
    e.bub = (lu || br) ? 1 : 0;
    e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (rst) begin
      if (lu && !br && m_sc < CMAX) m_sc++;
      if (br && m_fc < CMAX) m_fc++;
      m_fa = (lu || br) ? 0 : src_of(rs1);
      m_fb = (lu || br) ? 0 : src_of(rs2);
      flight[1] = flight[0];
      if (lu || br || !v) flight[0] = '{0, 0, 0};
      else                flight[0] = '{we, ld, rd};
    end
  endtask

  task automatic nop();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("fwd_a_sel",    int'(fwd_a_sel),    e.fa);
        chk("fwd_b_sel",    int'(fwd_b_sel),    e.fb);
        chk("pc_write",     int'(pc_write),     e.pcw);
        chk("if_id_write",  int'(if_id_write),  e.ifw);
        chk("if_id_flush",  int'(if_id_flush),  e.ifl);
        chk("id_ex_bubble", int'(id_ex_bubble), e.bub);
        chk("stall_count",  int'(stall_count),  e.sc);
        chk("flush_count",  int'(flush_count),  e.fc);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int budget;
    rst_n = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0; ex_branch_taken = 0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // add x5 -> immediate consumer (MEM select), then consumer two later (WB select)
    cyc(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 1, 5, 0, 1, 0, 6, 1, 0, 0);
    nop();
    cyc(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 1, 3, 3, 1, 1, 8, 1, 0, 0);
    cyc(1, 1, 5, 0, 1, 0, 9, 1, 0, 0);
    nop(); nop();

    // x5 producers in MEM and EX, consumer on rs2: youngest wins
    cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(1, 1, 0, 5, 0, 1, 10, 1, 0, 0);
    nop(); nop();

    // lw x7 then use: one stall, re-evaluated consumer gets WB
    cyc(1, 1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(1, 1, 7, 0, 1, 0, 11, 1, 0, 0);
    cyc(1, 1, 7, 0, 1, 0, 11, 1, 0, 0);
    nop(); nop();

    // load-use coinciding with a taken branch: flush wins
    cyc(1, 1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(1, 1, 7, 0, 1, 0, 11, 1, 0, 1);
    nop(); nop();

    // x0 destination and source never forward or stall
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    nop(); nop();

    // reset asserted in the stall cycle, then the consumer sees no stall
    cyc(1, 1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(0, 1, 7, 0, 1, 0, 11, 1, 0, 0);
    cyc(1, 1, 7, 0, 1, 0, 11, 1, 0, 0);
    nop();

    // randomized traffic on a small register set to provoke hazards and saturate counters
    for (int i = 0; i < 1200; i++) begin
      bit r;
      r = ($urandom_range(0, 99) != 0);
      cyc(r, ($urandom_range(0, 9) != 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
          1'($urandom), ($urandom_range(0, 2) == 0),
          r && ($urandom_range(0, 6) == 0));
    end
    nop();

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Forwarding and hazard controller for the 5-stage RISC-V pipeline. It tracks destination registers of in-flight instructions, drives the 2-bit selects of the two EX-stage operand forwarding muxes (`mux4_1` instances), and generates load-use stall and branch-flush controls for PC, IF/ID and ID/EX. Sits beside the pipeline registers and is fed from the ID and EX stages.

## Interface
- `CNT_W`, 16, width of the saturating stall/flush event counters
- `clk` input 1: pipeline clock, all state updates on its rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `id_valid` input 1: ID stage holds a real instruction
- `id_rs1`, `id_rs2` input 5 each: source register indices in ID
- `id_use_rs1`, `id_use_rs2` input 1 each: the instruction actually reads that source
- `id_rd` input 5: destination register index in ID
- `id_regwrite`, `id_memread` input 1 each: the ID instruction writes rd / is a load
- `ex_branch_taken` input 1: redirect resolved in EX this cycle
- `fwd_a_sel`, `fwd_b_sel` output 2 each: registered operand mux selects for EX
- `pc_write` output 1: PC register enable
- `if_id_write` output 1: IF/ID register enable
- `if_id_flush` output 1: clear IF/ID to NOP
- `id_ex_bubble` output 1: load NOP into ID/EX
- `stall_count`, `flush_count` output CNT_W each: saturating event counters

## Operation
- Shadow state per stage: EX (`ex_rd`, `ex_regwrite`, `ex_memread`), MEM (`mem_rd`, `mem_regwrite`), WB (`wb_rd`, `wb_regwrite`).
- Each cycle: WB<=MEM, MEM<=EX, EX<=ID fields. On `id_ex_bubble`, or when `id_valid`=0, EX<=zero (rd=0, regwrite=0, memread=0).
- Select encoding: 00 = register file (mux `ina`), 01 = WB result (`inb`), 10 = MEM ALU result (`inc`). 11 is never driven.
- Next `fwd_a_sel` when no bubble is inserted:
  - 10 if `ex_regwrite` and `ex_rd`!=0 and `ex_rd`==`id_rs1`
  - else 01 if `mem_regwrite` and `mem_rd`!=0 and `mem_rd`==`id_rs1`
  - else 00
  - `fwd_b_sel` uses the same rule with `id_rs2`.
- MEM-stage match has priority over WB (youngest producer wins). When a bubble is inserted, the next select is 00.
- x0 is never forwarded. WB-to-ID same-cycle hazards are resolved by the write-through register file, not by this block.
- `load_use` = `id_valid` & `ex_memread` & `ex_rd`!=0 & ((`id_use_rs1` & `ex_rd`==`id_rs1`) | (`id_use_rs2` & `ex_rd`==`id_rs2`)).
- `flush` = `ex_branch_taken`.
- Combinational controls:
  - `if_id_flush` = `flush`
  - `id_ex_bubble` = `load_use` | `flush`
  - `pc_write` = `if_id_write` = !(`load_use` & !`flush`)
  - Flush has priority over stall: the PC loads the branch target.
- Counters: `stall_count` +1 per cycle with `load_use` & !`flush`. `flush_count` +1 per cycle with `flush`. Both saturate at all-ones and do not wrap.

## Timing
- Reset (async assert, synchronous-edge release): all shadow state 0, `fwd_*_sel`=00, counters 0. Control outputs therefore come out of reset at `pc_write`=`if_id_write`=1, `if_id_flush`=`id_ex_bubble`=0.
- Forward selects are registered: computed from ID fields in cycle N, valid throughout cycle N+1 while that instruction is in EX.
- Load-use costs exactly one stall cycle. During the stall the load moves to MEM and EX holds a bubble. Next cycle the re-evaluated ID instruction matches in MEM and gets select 01 (WB).
- Back-to-back loads each stall independently; there is no multi-cycle stall state.
- Reset mid-stall clears everything; no stall persists after release.

## Structure
- Shared `riscv_pkg`: `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10, and `REG_IDX_W`=5.
- One sub-module `sat_counter` (parameter width, `inc` input, saturating), instantiated twice.
- Shadow pipeline and select logic live in the top module, roughly 150-250 lines total.

## Test plan
- `add x5` in EX, next instruction reads rs1=x5 -> `fwd_a_sel`=10 on the following cycle; two instructions later -> 01.
- Producers with rd=x5 in both EX and MEM, consumer rs2=x5 -> `fwd_b_sel`=10 (MEM priority).
- `lw x7` in EX, ID reads x7 with `id_use_rs1`=1 -> one cycle of `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1; `stall_count`=1; next cycle `fwd_a_sel`=01.
- Load-use and `ex_branch_taken` in the same cycle -> `pc_write`=1, `if_id_flush`=1, `id_ex_bubble`=1; `flush_count`+1, `stall_count` unchanged.
- rd=x0 writes and `id_rs1`=0 -> selects stay 00 and no stall. Preload counters near max -> they hold at all-ones.
- Assert `rst_n`=0 mid-stall -> all outputs return to their reset values immediately; no stall after release.
